// File: rtl/timing_pkg.sv
// Shared types and constants for the multi-channel timing generator (timing_gen_mc).
package timing_pkg;
    localparam int TGEN_N         = 28;
    localparam int TGEN_CH        = 4;
    localparam int TGEN_MIN_MODUL = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tgen_state_e;

    // Sized for the widest build; narrower instances use the low bits of each field.
    typedef struct packed {
        logic [TGEN_N-1:0]              modul;
        logic [TGEN_CH-1:0][TGEN_N-1:0] start;
        logic [TGEN_CH-1:0][TGEN_N-1:0] width;
        logic [TGEN_CH-1:0]             pol;
    } tgen_cfg_t;

    function automatic logic [TGEN_N-1:0] clamp_modul(input logic [TGEN_N-1:0] m);
        return (m < TGEN_N'(TGEN_MIN_MODUL)) ? TGEN_N'(TGEN_MIN_MODUL) : m;
    endfunction
endpackage

// File: rtl/tgen_window.sv
// One pulse channel: registered compare of the count against [start, start+width),
// truncated at the period end; outside RUN the output rests at the polarity level.
module tgen_window #(
    parameter int N = 28
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         gate,
    input  logic         pol,
    input  logic [N-1:0] q,
    input  logic [N-1:0] start,
    input  logic [N-1:0] width,
    input  logic [N-1:0] modul,
    output logic         ch
);
    logic [N:0] q_x;
    logic [N:0] lo_x;
    logic [N:0] hi_x;
    logic       hit;
    logic       ch_d;
    logic       ch_q;

    // One extra bit keeps start+width from wrapping back into range.
    always_comb begin
        q_x  = {1'b0, q};
        lo_x = {1'b0, start};
        hi_x = {1'b0, start} + {1'b0, width};
        hit  = (q_x >= lo_x) && (q_x < hi_x) && (q < modul);
        ch_d = (gate && hit) ^ pol;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_q <= 1'b0;
        end else if (en) begin
            ch_q <= ch_d;
        end
    end

    assign ch = ch_q;
endmodule

// File: rtl/timing_gen_mc.sv
// Multi-channel programmable timing generator: modulo counter, CH pulse windows and a shadowed
// valid/ready config port. Define TGEN_POLARITY_EN to add per-channel output polarity (cfg_pol).
module timing_gen_mc
    import timing_pkg::*;
#(
    parameter int N  = TGEN_N,
    parameter int CH = TGEN_CH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stop,
    input  logic            pause,
    input  logic            oneshot,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [N-1:0]    cfg_modul,
    input  logic [CH*N-1:0] cfg_start,
    input  logic [CH*N-1:0] cfg_width,
`ifdef TGEN_POLARITY_EN
    input  logic [CH-1:0]   cfg_pol,
`endif
    output logic [N-1:0]    q_out,
    output logic            wrap,
    output logic [CH-1:0]   ch_out,
    output logic            done,
    output logic            busy
);
    localparam logic [N-1:0] Q_ONE = N'(1);
    localparam tgen_cfg_t CFG_RESET = '{
        modul: TGEN_N'(TGEN_MIN_MODUL),
        start: '0,
        width: '0,
        pol:   '0
    };

    tgen_state_e       state_q;
    tgen_state_e       state_d;
    logic [N-1:0]      q_q;
    logic [N-1:0]      q_d;
    logic              wrap_q;
    logic              wrap_d;
    logic              done_q;
    logic              done_d;
    logic              busy_q;
    logic              busy_d;
    logic              oneshot_q;
    logic              oneshot_d;
    logic              pending_q;
    logic              pending_d;
    tgen_cfg_t         act_q;
    tgen_cfg_t         act_d;
    tgen_cfg_t         shd_q;
    tgen_cfg_t         cfg_in;
    logic [TGEN_N-1:0] meff_full;
    logic [TGEN_N-1:0] meff_d_full;
    logic [N-1:0]      meff;
    logic [N-1:0]      meff_d;
    logic              hs;
    logic              at_end;
    logic              apply;
    logic              run_gate;

    assign hs          = cfg_valid && !pending_q;
    assign meff_full   = clamp_modul(act_q.modul);
    assign meff        = meff_full[N-1:0];
    assign at_end      = (state_q == RUN) && (q_q >= meff - Q_ONE);

    always_comb begin
        cfg_in       = '0;
        cfg_in.modul = TGEN_N'(cfg_modul);
        for (int i = 0; i < CH; i++) begin
            cfg_in.start[i] = TGEN_N'(cfg_start[i*N +: N]);
            cfg_in.width[i] = TGEN_N'(cfg_width[i*N +: N]);
        end
`ifdef TGEN_POLARITY_EN
        cfg_in.pol = TGEN_CH'(cfg_pol);
`endif
    end

    // Shadow is plain data: only trusted once pending says a handshake filled it.
    always_ff @(posedge clk) begin
        if (hs) begin
            shd_q <= cfg_in;
        end
    end

    // stop beats start and wrap; pause freezes everything, swallowing start/stop.
    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        oneshot_d = oneshot_q;
        apply     = 1'b0;
        if (!pause) begin
            if (stop) begin
                state_d = IDLE;
                q_d     = '0;
                apply   = pending_q;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        apply = pending_q;
                        if (start) begin
                            state_d   = RUN;
                            q_d       = '0;
                            oneshot_d = oneshot;
                        end
                    end
                    RUN: begin
                        if (at_end) begin
                            q_d   = '0;
                            apply = pending_q;
                            if (oneshot_q) begin
                                state_d = DONE;
                            end
                        end else begin
                            q_d = q_q + Q_ONE;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        q_d     = '0;
                    end
                endcase
            end
        end
    end

    assign act_d       = apply ? shd_q : act_q;
    assign pending_d   = hs ? 1'b1 : (apply ? 1'b0 : pending_q);
    assign meff_d_full = clamp_modul(act_d.modul);
    assign meff_d      = meff_d_full[N-1:0];
    assign wrap_d      = (state_d == RUN) && (q_d == meff_d - Q_ONE);
    assign done_d      = (state_d == DONE);
    assign busy_d      = (state_d == RUN);
    assign run_gate    = (state_q == RUN) && (state_d == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            q_q       <= '0;
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            oneshot_q <= 1'b0;
            pending_q <= 1'b0;
            act_q     <= CFG_RESET;
        end else begin
            pending_q <= pending_d;
            if (!pause) begin
                state_q   <= state_d;
                q_q       <= q_d;
                wrap_q    <= wrap_d;
                done_q    <= done_d;
                busy_q    <= busy_d;
                oneshot_q <= oneshot_d;
                act_q     <= act_d;
            end
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        tgen_window #(
            .N(N)
        ) u_win (
            .clk   (clk),
            .reset (reset),
            .en    (!pause),
            .gate  (run_gate),
            .pol   (act_q.pol[i]),
            .q     (q_q),
            .start (act_q.start[i][N-1:0]),
            .width (act_q.width[i][N-1:0]),
            .modul (meff),
            .ch    (ch_out[i])
        );
    end

    assign q_out     = q_q;
    assign wrap      = wrap_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign cfg_ready = !pending_q;
endmodule

// File: tb/tb_timing_gen_mc.sv
// Table-driven, scoreboarded bench for timing_gen_mc; polarity vectors run when TGEN_POLARITY_EN is defined.
module tb_timing_gen_mc;
    localparam int N  = 28;
    localparam int CH = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic            pause = 1'b0;
    logic            oneshot = 1'b0;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [N-1:0]    cfg_modul = '0;
    logic [CH*N-1:0] cfg_start = '0;
    logic [CH*N-1:0] cfg_width = '0;
`ifdef TGEN_POLARITY_EN
    logic [CH-1:0]   cfg_pol = '0;
`endif
    logic [N-1:0]    q_out;
    logic            wrap;
    logic [CH-1:0]   ch_out;
    logic            done;
    logic            busy;

    timing_gen_mc #(.N(N), .CH(CH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .oneshot   (oneshot),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_modul (cfg_modul),
        .cfg_start (cfg_start),
        .cfg_width (cfg_width),
`ifdef TGEN_POLARITY_EN
        .cfg_pol   (cfg_pol),
`endif
        .q_out     (q_out),
        .wrap      (wrap),
        .ch_out    (ch_out),
        .done      (done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit          st, sp, pa, os, cv;
        int unsigned modul, s0, w0, s1, w1;
        bit [3:0]    pol;
        int unsigned eq;
        bit          ew;
        bit [3:0]    ech;
        bit          ed, eb, er;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   total = 0;
    int   bad = 0;

    function automatic vec_t vc(bit st, bit sp, bit pa, bit os, int unsigned q, bit w,
                                bit [3:0] ch, bit d, bit b, bit r);
        vec_t v;
        v = '0;
        v.st = st; v.sp = sp; v.pa = pa; v.os = os;
        v.eq = q; v.ew = w; v.ech = ch; v.ed = d; v.eb = b; v.er = r;
        return v;
    endfunction

    function automatic vec_t vg(int unsigned m, int unsigned s0, int unsigned w0, int unsigned s1,
                                int unsigned w1, bit [3:0] pol, int unsigned q, bit w,
                                bit [3:0] ch, bit d, bit b, bit r);
        vec_t v;
        v = vc(1'b0, 1'b0, 1'b0, 1'b0, q, w, ch, d, b, r);
        v.cv = 1'b1; v.modul = m; v.s0 = s0; v.w0 = w0; v.s1 = s1; v.w1 = w1; v.pol = pol;
        return v;
    endfunction

    function automatic vec_t rn(int unsigned q, bit w, bit [3:0] ch, bit r);
        return vc(1'b0, 1'b0, 1'b0, 1'b0, q, w, ch, 1'b0, 1'b1, r);
    endfunction

    function automatic vec_t vi(bit r);
        return vc(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 4'b0000, 1'b0, 1'b0, r);
    endfunction

    task automatic drive(input vec_t v);
        start     = v.st;
        stop      = v.sp;
        pause     = v.pa;
        oneshot   = v.os;
        cfg_valid = v.cv;
        if (v.cv) begin
            cfg_modul = N'(v.modul);
            cfg_start = '0;
            cfg_width = '0;
            cfg_start[0 +: N] = N'(v.s0);
            cfg_width[0 +: N] = N'(v.w0);
            cfg_start[N +: N] = N'(v.s1);
            cfg_width[N +: N] = N'(v.w1);
`ifdef TGEN_POLARITY_EN
            cfg_pol = v.pol;
`endif
        end
    endtask

    task automatic cmp(input string tag, input int unsigned eq, input bit ew, input bit [3:0] ech,
                       input bit ed, input bit eb, input bit er);
        total++;
        if (q_out !== N'(eq) || wrap !== ew || ch_out !== ech || done !== ed || busy !== eb
            || cfg_ready !== er) begin
            bad++;
            $display("FAIL %s: got q=%0d wrap=%b ch=%b done=%b busy=%b rdy=%b, want q=%0d wrap=%b ch=%b done=%b busy=%b rdy=%b",
                     tag, q_out, wrap, ch_out, done, busy, cfg_ready, eq, ew, ech, ed, eb, er);
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        drive(v);
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        cmp(tag, e.eq, e.ew, e.ech, e.ed, e.eb, e.er);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        // continuous, modul 5, ch0 window 1..2
        tbl.push_back(vg(5, 1, 2, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0));
        tbl.push_back(vi(1));
        tbl.push_back(vc(1, 0, 0, 0, 0, 0, 4'h0, 0, 1, 1));
        tbl.push_back(rn(1, 0, 4'h0, 1));
        tbl.push_back(rn(2, 0, 4'h1, 1));
        tbl.push_back(rn(3, 0, 4'h1, 1));
        tbl.push_back(rn(4, 1, 4'h0, 1));
        tbl.push_back(rn(0, 0, 4'h0, 1));
        tbl.push_back(rn(1, 0, 4'h0, 1));
        tbl.push_back(rn(2, 0, 4'h1, 1));
        tbl.push_back(vc(0, 1, 0, 0, 0, 0, 4'h0, 0, 0, 1));
        // oneshot, modul 4, ch0 window 0..0
        tbl.push_back(vg(4, 0, 1, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0));
        tbl.push_back(vi(1));
        tbl.push_back(vc(1, 0, 0, 1, 0, 0, 4'h0, 0, 1, 1));
        tbl.push_back(rn(1, 0, 4'h1, 1));
        tbl.push_back(rn(2, 0, 4'h0, 1));
        tbl.push_back(rn(3, 1, 4'h0, 1));
        tbl.push_back(vc(0, 0, 0, 0, 0, 0, 4'h0, 1, 0, 1));
        tbl.push_back(vc(0, 0, 0, 0, 0, 0, 4'h0, 1, 0, 1));
        tbl.push_back(vc(1, 0, 0, 1, 0, 0, 4'h0, 0, 1, 1));
        tbl.push_back(rn(1, 0, 4'h1, 1));
        tbl.push_back(rn(2, 0, 4'h0, 1));
        tbl.push_back(rn(3, 1, 4'h0, 1));
        tbl.push_back(vc(0, 0, 0, 0, 0, 0, 4'h0, 1, 0, 1));
        tbl.push_back(vc(0, 1, 0, 0, 0, 0, 4'h0, 0, 0, 1));
        // modul 8 with dead channels, reconfigure mid-period and on the wrap
        tbl.push_back(vg(8, 0, 0, 9, 3, 4'h0, 0, 0, 4'h0, 0, 0, 0));
        tbl.push_back(vi(1));
        tbl.push_back(vc(1, 0, 0, 0, 0, 0, 4'h0, 0, 1, 1));
        tbl.push_back(rn(1, 0, 4'h0, 1));
        tbl.push_back(rn(2, 0, 4'h0, 1));
        tbl.push_back(vg(3, 0, 0, 9, 3, 4'h0, 3, 0, 4'h0, 0, 1, 0));
        tbl.push_back(rn(4, 0, 4'h0, 0));
        tbl.push_back(rn(5, 0, 4'h0, 0));
        tbl.push_back(rn(6, 0, 4'h0, 0));
        tbl.push_back(rn(7, 1, 4'h0, 0));
        tbl.push_back(rn(0, 0, 4'h0, 1));
        tbl.push_back(rn(1, 0, 4'h0, 1));
        tbl.push_back(rn(2, 1, 4'h0, 1));
        tbl.push_back(vg(5, 0, 0, 9, 3, 4'h0, 0, 0, 4'h0, 0, 1, 0));
        tbl.push_back(rn(1, 0, 4'h0, 0));
        tbl.push_back(rn(2, 1, 4'h0, 0));
        tbl.push_back(rn(0, 0, 4'h0, 1));
        tbl.push_back(rn(1, 0, 4'h0, 1));
        tbl.push_back(rn(2, 0, 4'h0, 1));
        tbl.push_back(rn(3, 0, 4'h0, 1));
        tbl.push_back(rn(4, 1, 4'h0, 1));
        tbl.push_back(vc(0, 1, 0, 0, 0, 0, 4'h0, 0, 0, 1));
        // modul 0 and 1 clamp to 2
        tbl.push_back(vg(0, 0, 1, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0));
        tbl.push_back(vi(1));
        tbl.push_back(vc(1, 0, 0, 0, 0, 0, 4'h0, 0, 1, 1));
        tbl.push_back(rn(1, 1, 4'h1, 1));
        tbl.push_back(rn(0, 0, 4'h0, 1));
        tbl.push_back(rn(1, 1, 4'h1, 1));
        tbl.push_back(vc(0, 1, 0, 0, 0, 0, 4'h0, 0, 0, 1));
        tbl.push_back(vg(1, 0, 1, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0));
        tbl.push_back(vi(1));
        tbl.push_back(vc(1, 0, 0, 0, 0, 0, 4'h0, 0, 1, 1));
        tbl.push_back(rn(1, 1, 4'h1, 1));
        tbl.push_back(rn(0, 0, 4'h0, 1));
        tbl.push_back(vc(0, 1, 0, 0, 0, 0, 4'h0, 0, 0, 1));
        // pause holds, swallowed pulses, stop+start, handshake while paused
        tbl.push_back(vg(5, 2, 3, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0));
        tbl.push_back(vi(1));
        tbl.push_back(vc(1, 0, 0, 0, 0, 0, 4'h0, 0, 1, 1));
        tbl.push_back(rn(1, 0, 4'h0, 1));
        tbl.push_back(rn(2, 0, 4'h0, 1));
        tbl.push_back(rn(3, 0, 4'h1, 1));
        tbl.push_back(vc(0, 0, 1, 0, 3, 0, 4'h1, 0, 1, 1));
        tbl.push_back(vc(0, 1, 1, 0, 3, 0, 4'h1, 0, 1, 1));
        tbl.push_back(vc(1, 0, 1, 0, 3, 0, 4'h1, 0, 1, 1));
        tbl.push_back(rn(4, 1, 4'h1, 1));
        tbl.push_back(vc(0, 0, 1, 0, 4, 1, 4'h1, 0, 1, 1));
        tbl.push_back(rn(0, 0, 4'h1, 1));
        tbl.push_back(rn(1, 0, 4'h0, 1));
        tbl.push_back(vc(1, 1, 0, 0, 0, 0, 4'h0, 0, 0, 1));
        tbl.push_back(vi(1));
        v = vg(3, 0, 0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0);
        v.pa = 1'b1;
        tbl.push_back(v);
        tbl.push_back(vc(0, 0, 1, 0, 0, 0, 4'h0, 0, 0, 0));
        tbl.push_back(vi(1));
        tbl.push_back(vc(1, 0, 0, 0, 0, 0, 4'h0, 0, 1, 1));
        tbl.push_back(rn(1, 0, 4'h0, 1));
        tbl.push_back(rn(2, 1, 4'h0, 1));
        tbl.push_back(vc(0, 1, 0, 0, 0, 0, 4'h0, 0, 0, 1));

        repeat (3) @(posedge clk);
        #1;
        cmp("reset_state", 0, 0, 4'h0, 0, 0, 1);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // async reset mid-run with a config pending (modul 3 active)
        step(vc(1, 0, 0, 0, 0, 0, 4'h0, 0, 1, 1), "rst_run0");
        step(rn(1, 0, 4'h0, 1), "rst_run1");
        step(vg(7, 0, 0, 0, 0, 4'h0, 2, 1, 4'h0, 0, 1, 0), "rst_cfg");
        @(negedge clk);
        drive(vi(1));
        #2;
        reset = 1'b1;
        #1;
        cmp("rst_async", 0, 0, 4'h0, 0, 0, 1);
        @(posedge clk);
        #1;
        cmp("rst_hold", 0, 0, 4'h0, 0, 0, 1);
        @(negedge clk);
        reset = 1'b0;
        step(vc(1, 0, 0, 0, 0, 0, 4'h0, 0, 1, 1), "post_rst0");
        step(rn(1, 1, 4'h0, 1), "post_rst1");
        step(rn(0, 0, 4'h0, 1), "post_rst2");
        step(rn(1, 1, 4'h0, 1), "post_rst3");
        step(vc(0, 1, 0, 0, 0, 0, 4'h0, 0, 0, 1), "post_rst_stop");

`ifdef TGEN_POLARITY_EN
        step(vg(5, 1, 2, 0, 0, 4'h1, 0, 0, 4'h0, 0, 0, 0), "pol_cfg");
        step(vi(1), "pol_apply");
        step(vc(0, 0, 0, 0, 0, 0, 4'h1, 0, 0, 1), "pol_idle");
        step(vc(1, 0, 0, 0, 0, 0, 4'h1, 0, 1, 1), "pol_run0");
        step(rn(1, 0, 4'h1, 1), "pol_run1");
        step(rn(2, 0, 4'h0, 1), "pol_run2");
        step(rn(3, 0, 4'h0, 1), "pol_run3");
        step(rn(4, 1, 4'h1, 1), "pol_run4");
        step(vc(0, 1, 0, 0, 0, 0, 4'h1, 0, 0, 1), "pol_stop");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/timing_gen_mc.md
Name: timing_gen_mc

Overview:
Multi-channel programmable timing generator. It is the successor of the single-modulus wrap counter and has these additions:
- free-running modulo counter;
- CH independent pulse channels, each with a programmable start and width;
- a valid/ready configuration port with shadow registers, applied glitch-free at the period boundary;
- continuous and one-shot modes.
It sits under the timing top level and drives sync/strobe outputs.

Parameters:
N, 28, counter/config field width in bits
CH, 4, number of pulse channels

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; IDLE/DONE -> RUN
stop  in  1  single-cycle pulse; any state -> IDLE
pause  in  1  high = freeze counter, state and outputs (hold)
oneshot  in  1  mode, sampled on start: 1 = one period then DONE, 0 = continuous
cfg_valid  in  1  config offered
cfg_ready  out  1  config accepted when cfg_valid & cfg_ready
cfg_modul  in  N  period length
cfg_start  in  CH*N  per-channel pulse start count, channel i at [i*N +: N]
cfg_width  in  CH*N  per-channel pulse width in counts
q_out  out  N  current count
wrap  out  1  high while q_out == active modul-1 in RUN
ch_out  out  CH  channel pulses
done  out  1  high in DONE
busy  out  1  high in RUN

Behaviour:
- Reset (async):
  - state IDLE, q_out=0, wrap=0, ch_out=0, done=0, busy=0, cfg_ready=1;
  - active config: modul=2, all start=0, all width=0; no pending config.
- States:
  - IDLE: q=0; outputs low. start -> RUN with q=0.
  - RUN: q increments each un-paused cycle; after modul-1, q goes to 0. At the wrap, oneshot=1 -> DONE, else stay in RUN.
  - DONE: q=0, done=1, ch_out=0. start -> RUN.
  - stop has priority over start and wrap. The state is IDLE on the next edge, q=0.
- pause=1: no register changes at all, except that a config handshake may still complete. pause takes priority over start/stop, and those pulses are lost.
- Arithmetic:
  - Active modul values below 2 are clamped to 2.
  - Pulse-window compares are done in N+1 bits, with no overflow.
- Channel i, registered:
  - ch_out[i] is high in the cycle after q_out satisfies start_i <= q_out < start_i + width_i, with q_out < modul.
  - Latency: 1 cycle relative to q_out.
  - width=0 or start>=modul gives no pulse.
  - A window past modul-1 is truncated, not wrapped.
- wrap is registered and asserted together with q_out==modul-1 (decoded from modul-2 on the prior cycle), while in RUN.
- Config port:
  - cfg_ready = !pending.
  - A handshake latches all fields into the shadow registers and sets pending.
  - In IDLE/DONE, the shadow is copied to active on the next edge.
  - In RUN, the copy happens on the edge where q returns to 0.
  - If a handshake and a wrap happen on the same cycle, the new config waits for the following wrap.
  - stop with pending set: the copy happens on the edge entering IDLE.
- Reset mid-operation clears pending; shadow contents are discarded.

Optional Feature:
Macro TGEN_POLARITY_EN.
- Defined:
  - adds a per-channel cfg_pol input (CH bits), shadowed and applied like the other config fields;
  - ch_out[i] = window XOR pol[i] while in RUN;
  - in IDLE/DONE, ch_out = pol, giving an idle level;
  - reset value of pol is 0.
- Undefined: no port, outputs active-high only.

Decomposition:
- Package timing_pkg:
  - state enum tgen_state_e {IDLE, RUN, DONE};
  - constant TGEN_MIN_MODUL=2;
  - typedef tgen_cfg_t struct (modul, start[], width[], pol).
- Sub-module tgen_window (one instance per channel): a registered compare of q against start/width/modul, with output ch.

Test Plan:
- Modul 5, ch0 start=1 width=2, continuous. Start -> q_out 0,1,2,3,4,0; ch_out[0] high when q_out=2,3; wrap high at q_out=4.
- Oneshot, modul 4 -> one period 0..3, then DONE: done=1, q_out=0; a start pulse reruns the period.
- In RUN with modul 8, write modul=3 when q=2 -> cfg_ready=0 until wrap; the next period counts 0,1,2; a write coinciding with the wrap is applied one period later.
- Config modul=0 and modul=1 -> counter behaves as modul 2 (0,1,0). Ch width=0 and ch start=9 with modul 8 -> ch_out stays 0.
- Pause for 3 cycles at q=3 -> q_out, ch_out and wrap held. Stop and start in the same cycle -> IDLE. Reset asserted mid-RUN -> all outputs 0 asynchronously, modul back to 2.
- With TGEN_POLARITY_EN, pol=1 -> ch_out=1 in IDLE and low inside the window.
